// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage ahead of the main decoder.
// Owns the program counter, fetches one word at a time over a
// request/ready handshake, holds it in the instruction register until
// the downstream stage acknowledges it, then advances or redirects.
// A misaligned redirect parks the unit in a sticky fault state.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_ack,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        fault,
    output logic [31:0] instret
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]  state_reg,    state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] instr_reg,    instr_next;
    logic [31:0] pc_reg,       pc_next;
    logic [31:0] instret_reg,  instret_next;

    // Handshake outputs are pure functions of the state, so the request
    // and its address stay put until the memory answers.
    assign imem_req    = (state_reg == ST_FETCH);
    assign instr_valid = (state_reg == ST_HOLD);
    assign fault       = (state_reg == ST_FAULT);
    assign imem_addr   = fetch_pc_reg;
    assign instr       = instr_reg;
    assign op          = instr_reg[6:0];
    assign pc          = pc_reg;
    assign pc_plus4    = pc_reg + 32'd4;
    assign instret     = instret_reg;

    // Next-state logic: capture on ready, advance/redirect/fault on ack.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        instr_next    = instr_reg;
        pc_next       = pc_reg;
        instret_next  = instret_reg;
        case (state_reg)
            ST_FETCH: begin
                if (imem_ready) begin
                    instr_next = imem_rdata;
                    pc_next    = fetch_pc_reg;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ack) begin
                    instret_next = instret_reg + 32'd1;
                    if (!redirect) begin
                        fetch_pc_next = pc_reg + 32'd4;
                        state_next    = ST_FETCH;
                    end else if (redirect_target[1:0] == 2'b00) begin
                        fetch_pc_next = redirect_target;
                        state_next    = ST_FETCH;
                    end else begin
                        // Misaligned target: stop fetching, keep fetch_pc.
                        state_next = ST_FAULT;
                    end
                end
            end
            default: begin
                // Fault (and the unused encoding) is left only by reset.
                state_next = ST_FAULT;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_FETCH;
            fetch_pc_reg <= RESET_PC;
            instr_reg    <= 32'd0;
            pc_reg       <= 32'd0;
            instret_reg  <= 32'd0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            instr_reg    <= instr_next;
            pc_reg       <= pc_next;
            instret_reg  <= instret_next;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed stimulus for ifetch_unit, checked every cycle
// against a transaction-level model plus hand-computed literal values.
module tb_ifetch_unit;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_ack = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [6:0]  op;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;
    logic [31:0] instret;

    ifetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .op(op), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .instr_ack(instr_ack), .redirect(redirect),
        .redirect_target(redirect_target),
        .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = waiting on memory, 1 = holding an instruction,
    // 2 = faulted. Addresses and counts kept as plain 32-bit arithmetic.
    int          m_mode  = 0;
    logic [31:0] m_addr  = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pc    = 32'd0;
    logic [31:0] m_count = 32'd0;
    bit          m_live  = 1'b0;

    // Model update on each edge, then compare all outputs 1 time unit later.
    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_addr = RPC; m_instr = 0; m_pc = 0; m_count = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            if (m_mode == 0 && imem_ready) begin
                m_instr = imem_rdata;
                m_pc    = m_addr;
                m_mode  = 1;
            end else if (m_mode == 1 && instr_ack) begin
                m_count = m_count + 32'd1;
                if (redirect && redirect_target[1:0] != 2'b00) begin
                    m_mode = 2;
                end else begin
                    m_addr = redirect ? redirect_target : m_pc + 32'd4;
                    m_mode = 0;
                end
            end
        end
        #1;
        if (m_live) begin
            chk("imem_req",    32'(imem_req),    32'(m_mode == 0));
            chk("instr_valid", 32'(instr_valid), 32'(m_mode == 1));
            chk("fault",       32'(fault),       32'(m_mode == 2));
            chk("imem_addr",   imem_addr,        m_addr);
            chk("instr",       instr,            m_instr);
            chk("op",          32'(op),          32'(m_instr[6:0]));
            chk("pc",          pc,               m_pc);
            chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
            chk("instret",     instret,          m_count);
        end
    end

    // Apply one cycle of inputs (called at a falling edge, returns at the next).
    task automatic cyc(input logic rst, input logic rdy, input logic [31:0] rd,
                       input logic ack, input logic red, input logic [31:0] tgt);
        reset = rst; imem_ready = rdy; imem_rdata = rd;
        instr_ack = ack; redirect = red; redirect_target = tgt;
        @(negedge clk);
        $display("cyc t=%0t rst=%0b rdy=%0b rd=%h ack=%0b red=%0b tgt=%h -> req=%0b addr=%h v=%0b pc=%h flt=%0b instret=%0d",
                 $time, rst, rdy, rd, ack, red, tgt, imem_req, imem_addr, instr_valid, pc, fault, instret);
    endtask

    initial begin
        // Reset with ready asserted: ready must be ignored.
        cyc(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("rst_req",  32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, 32'h1000);
        chk("rst_p4",   pc_plus4, 32'd4);
        chk("rst_instr", instr, 32'd0);

        // First fetch, zero wait.
        cyc(0, 1, 32'h0050_0093, 0, 0, 0);
        chk("f1_valid", 32'(instr_valid), 32'd1);
        chk("f1_op",    32'(op), 32'h13);
        chk("f1_pc",    pc, 32'h1000);
        chk("f1_p4",    pc_plus4, 32'h1004);

        // Sequential ack, then three wait states.
        cyc(0, 0, 0, 1, 0, 0);
        chk("a1_req",   32'(imem_req), 32'd1);
        chk("a1_addr",  imem_addr, 32'h1004);
        chk("a1_cnt",   instret, 32'd1);
        chk("a1_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 32'h4000);
        chk("w_addr",  imem_addr, 32'h1004);
        chk("w_valid", 32'(instr_valid), 32'd0);
        cyc(0, 1, 32'h00A0_0113, 0, 0, 0);

        // Hold for 5 cycles; redirect without ack ignored, ready ignored.
        for (int i = 0; i < 5; i++) cyc(0, 1, 32'h1111_1111, 0, 1, 32'h3000);
        chk("h_pc",    pc, 32'h1004);
        chk("h_instr", instr, 32'h00A0_0113);
        chk("h_req",   32'(imem_req), 32'd0);
        cyc(0, 0, 0, 1, 1, 32'h2000);
        chk("r_addr", imem_addr, 32'h2000);
        chk("r_cnt",  instret, 32'd2);

        // Misaligned redirect -> sticky fault.
        cyc(0, 1, 32'h0000_006F, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h2002);
        chk("flt", 32'(fault), 32'd1);
        for (int i = 0; i < 10; i++) cyc(0, 1, $urandom, 1, 0, 0);
        chk("flt_req",  32'(imem_req), 32'd0);
        chk("flt_cnt",  instret, 32'd3);
        chk("flt_addr", imem_addr, 32'h2000);

        // Reset clears fault; reset again during FETCH with ready high.
        cyc(1, 0, 0, 0, 0, 0);
        chk("rc_flt",  32'(fault), 32'd0);
        chk("rc_addr", imem_addr, 32'h1000);
        cyc(1, 1, 32'h1234_5678, 0, 0, 0);
        chk("rf_valid", 32'(instr_valid), 32'd0);
        chk("rf_addr",  imem_addr, 32'h1000);
        chk("rf_cnt",   instret, 32'd0);

        // Streams with varied wait states and ack delays.
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < k; w++) cyc(0, 0, 0, 1, 0, 0);
            cyc(0, 1, $urandom, 0, 0, 0);
            for (int w = 0; w < (3 - k); w++) cyc(0, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 1, (k == 2), 32'h0000_0100);
        end
        chk("s_cnt", instret, 32'd4);

        // PC wrap at the top of the address space.
        cyc(0, 1, 32'h0000_0013, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
        cyc(0, 1, 32'h0000_0033, 0, 0, 0);
        chk("wr_pc", pc, 32'hFFFF_FFFC);
        chk("wr_p4", pc_plus4, 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("wr_addr", imem_addr, 32'd0);

        // instret wrap via a forced count while holding.
        cyc(0, 1, 32'h0000_0063, 0, 0, 0);
        force dut.instret_reg = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        #1;
        release dut.instret_reg;
        cyc(0, 0, 0, 0, 0, 0);
        chk("ic_pre", instret, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 1, 0, 0);
        chk("ic_wrap", instret, 32'd0);
        chk("ic_addr", imem_addr, 32'd4);

        cyc(0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
